stack_arbiter: RTL and testbench
================================

STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter DEPTH, default 16, entries per stack; power of two, >= 2.
REQ-002 Clock  in  1  single clock; all state changes on rising edge.
REQ-003 Reset  in  1  reset, synchronous and active-high.
REQ-004 dt_cmd  in  SC_N  data-stack command: SC_NON, SC_PUS, SC_POP, SC_TOP or SC_CLR.
REQ-005 dt_wdata  in  CD_N  data-stack push value.
REQ-006 dt_rdata  out  CD_N  data-stack POP/TOP result.
REQ-007 dt_ack  out  1  one-cycle completion pulse for a data-stack command.
REQ-008 dt_empty, dt_full, dt_err  out  1 each  data-stack status flags.
REQ-009 op_cmd  in  SC_N  operator-stack command, same encoding as dt_cmd.
REQ-010 op_wdata  in  CO_N  operator push value.
REQ-011 op_rdata  out  CO_N  operator-stack POP/TOP result.
REQ-012 op_ack, op_empty, op_full, op_err  out  1 each  operator-stack handshake and flags.

Function
REQ-013 Both stacks SHALL share one single-port RAM of 2*DEPTH x CD_N words.
- Data stack: addresses 0..DEPTH-1.
- Operator stack: addresses DEPTH..2*DEPTH-1.
REQ-014 Each stack SHALL keep a pointer sp, range 0..DEPTH.
- empty = (sp==0); full = (sp==DEPTH).
REQ-015 Arbiter FSM SHALL have three states: IDLE, ACCESS, RESP.
- IDLE -> ACCESS when either cmd != SC_NON, latching the grant.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-016 ACCESS SHALL perform exactly one RAM operation for the granted port, by command:
- PUS: write mem[base+sp] and increment sp.
- POP: read mem[base+sp-1] and decrement sp.
- TOP: read mem[base+sp-1]; sp unchanged.
- CLR: no RAM access; sp <= 0.
REQ-017 In RESP the granted port's ack SHALL be 1 for exactly one cycle.
- Read data SHALL be valid on rdata in that cycle and held until the next read completes.
- Latency SHALL be 2 cycles from request sampled in IDLE to ack; one command per 3 cycles maximum.
REQ-018 Requesters SHALL hold cmd and wdata stable until ack, and present SC_NON or a new command the cycle after ack.
REQ-019 Operator push data SHALL be zero-extended to CD_N; op_rdata SHALL be the low CO_N bits of the read word.
REQ-020 PUS while full, or POP/TOP while empty, SHALL:
- not change sp or the RAM;
- leave rdata unchanged;
- set that port's sticky err;
- still produce ack.
REQ-021 CLR SHALL clear that port's err and sp; the other stack SHALL be unaffected.
REQ-022 The losing requester SHALL wait in IDLE and be granted on the next IDLE with its cmd still pending.

Reset
REQ-023 Reset SHALL take priority over all activity, including mid-ACCESS or mid-RESP; after Reset:
- FSM = IDLE;
- both sp = 0;
- all ack = 0 and all err = 0;
- dt_rdata = 0 and op_rdata = 0;
- empty = 1 and full = 0;
- round-robin pointer favours the data stack.
REQ-024 RAM contents SHALL NOT be cleared by Reset.

Configuration
REQ-025 With STACK_ARB_RR_EN defined, simultaneous requests in IDLE SHALL be granted round-robin, alternating from the last granted port.
REQ-026 Without STACK_ARB_RR_EN, simultaneous requests SHALL always grant the data stack (fixed priority).

Structure
REQ-027 SC_* command codes and SC_N, CD_N, CO_N SHALL come from the shared stack/CPU interface headers; FSM state codes SHALL be added to the shared controller-internal header.
REQ-028 The RAM SHALL be a separate sub-module stack_ram: synchronous write and registered read, parameterised on depth and width.

Verification
REQ-029 Reset; dt PUS 0x12, PUS 0x34, then POP -> each ack 2 cycles after request; POP returns 0x34; dt_empty=0 with sp=1.
REQ-030 op PUS 0x3, TOP, POP, POP -> TOP and first POP return 0x3; second POP sets op_err=1, op_rdata stays 0x3, op_ack still pulses.
REQ-031 Fill dt with DEPTH pushes -> dt_full=1; next PUS sets dt_err and leaves top value intact; dt CLR -> dt_empty=1, dt_err=0, op stack unchanged.
REQ-032 dt and op issue PUS in the same cycle, RR enabled -> dt acked first and op acked 3 cycles later; repeat -> op acked first; RR disabled -> dt acked first both times.
REQ-033 Assert Reset during ACCESS of a dt PUS -> no ack; dt_empty=1 the cycle after Reset; next PUS writes address 0.

Source files
------------

// File: rtl/stack_arbiter_pkg.sv
// Shared stack/CPU interface codes plus controller-internal FSM state codes for stack_arbiter.
package stack_arbiter_pkg;

    localparam int SC_N = 3;
    localparam int CD_N = 8;
    localparam int CO_N = 4;

    localparam logic [SC_N-1:0] SC_NON = 3'd0;
    localparam logic [SC_N-1:0] SC_PUS = 3'd1;
    localparam logic [SC_N-1:0] SC_POP = 3'd2;
    localparam logic [SC_N-1:0] SC_TOP = 3'd3;
    localparam logic [SC_N-1:0] SC_CLR = 3'd4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Operator words live zero-extended in the shared data-width RAM.
    function automatic logic [CD_N-1:0] op_extend(input logic [CO_N-1:0] v);
        return {{(CD_N-CO_N){1'b0}}, v};
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Single-port RAM for the two stacks: synchronous write, registered read, contents never reset.
module stack_ram #(
    parameter int WORDS = 32,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [WORDS];

    // Write port and registered read port share one address.
    always_ff @(posedge clk) begin
        if (we) mem_r[addr] <= wdata;
        if (re) rdata <= mem_r[addr];
    end

endmodule

// File: rtl/stack_arbiter.sv
// Data and operator stacks sharing one RAM behind an IDLE/ACCESS/RESP arbiter.
// Define STACK_ARB_RR_EN for round-robin on contention; otherwise the data stack always wins.
module stack_arbiter
    import stack_arbiter_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SC_N-1:0] dt_cmd,
    input  logic [CD_N-1:0] dt_wdata,
    output logic [CD_N-1:0] dt_rdata,
    output logic            dt_ack,
    output logic            dt_empty,
    output logic            dt_full,
    output logic            dt_err,
    input  logic [SC_N-1:0] op_cmd,
    input  logic [CO_N-1:0] op_wdata,
    output logic [CO_N-1:0] op_rdata,
    output logic            op_ack,
    output logic            op_empty,
    output logic            op_full,
    output logic            op_err
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] SP_FULL = PW'(DEPTH);
    localparam logic [PW-1:0] SP_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] SP_ONE  = {{(PW-1){1'b0}}, 1'b1};

    logic [1:0]      state_r;
    logic [PW-1:0]   dt_sp_r, op_sp_r;
    logic            gnt_op_r, rd_ok_r;
    logic [SC_N-1:0] cmd_r;
    logic [CD_N-1:0] wdata_r;
    logic [CD_N-1:0] dt_rdata_r;
    logic [CO_N-1:0] op_rdata_r;
    logic            dt_ack_r, op_ack_r, dt_err_r, op_err_r;

    logic            dt_req_s, op_req_s, gnt_op_s;
    logic [PW-1:0]   sel_sp_s, idx_s, next_sp_s;
    logic            sel_full_s, sel_empty_s, is_pus_s, is_rd_s;
    logic            wr_ok_s, rd_ok_s, bad_s;
    logic            ram_we_s, ram_re_s;
    logic [PW-1:0]   ram_addr_s;
    logic [CD_N-1:0] ram_q_s;

    assign dt_req_s = (dt_cmd != SC_NON);
    assign op_req_s = (op_cmd != SC_NON);

`ifdef STACK_ARB_RR_EN
    logic rr_op_r;

    // Contention winner alternates; the pointer only moves when both ports request.
    always_ff @(posedge clk) begin
        if (reset) rr_op_r <= 1'b0;
        else if (state_r == ST_IDLE && dt_req_s && op_req_s) rr_op_r <= !gnt_op_s;
    end

    assign gnt_op_s = op_req_s && (!dt_req_s || rr_op_r);
`else
    assign gnt_op_s = op_req_s && !dt_req_s;
`endif

    // Decode the latched command against the granted stack's pointer.
    always_comb begin
        sel_sp_s    = gnt_op_r ? op_sp_r : dt_sp_r;
        sel_full_s  = (sel_sp_s == SP_FULL);
        sel_empty_s = (sel_sp_s == SP_ZERO);
        is_pus_s    = (cmd_r == SC_PUS);
        is_rd_s     = (cmd_r == SC_POP) || (cmd_r == SC_TOP);
        wr_ok_s     = is_pus_s && !sel_full_s;
        rd_ok_s     = is_rd_s && !sel_empty_s;
        bad_s       = (is_pus_s && sel_full_s) || (is_rd_s && sel_empty_s);
        idx_s       = is_pus_s ? sel_sp_s : sel_sp_s - SP_ONE;
        ram_addr_s  = {gnt_op_r, idx_s[PW-2:0]};
        ram_we_s    = (state_r == ST_ACCESS) && wr_ok_s && !reset;
        ram_re_s    = (state_r == ST_ACCESS) && rd_ok_s && !reset;
        case (cmd_r)
            SC_PUS:  next_sp_s = wr_ok_s ? sel_sp_s + SP_ONE : sel_sp_s;
            SC_POP:  next_sp_s = rd_ok_s ? sel_sp_s - SP_ONE : sel_sp_s;
            SC_CLR:  next_sp_s = SP_ZERO;
            default: next_sp_s = sel_sp_s;
        endcase
    end

    stack_ram #(.WORDS(2*DEPTH), .WIDTH(CD_N)) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .addr  (ram_addr_s),
        .wdata (wdata_r),
        .rdata (ram_q_s)
    );

    // Arbiter FSM, stack pointers, sticky errors, acks and held read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            dt_sp_r    <= SP_ZERO;
            op_sp_r    <= SP_ZERO;
            gnt_op_r   <= 1'b0;
            rd_ok_r    <= 1'b0;
            cmd_r      <= SC_NON;
            wdata_r    <= {CD_N{1'b0}};
            dt_rdata_r <= {CD_N{1'b0}};
            op_rdata_r <= {CO_N{1'b0}};
            dt_ack_r   <= 1'b0;
            op_ack_r   <= 1'b0;
            dt_err_r   <= 1'b0;
            op_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (dt_req_s || op_req_s) begin
                        gnt_op_r <= gnt_op_s;
                        cmd_r    <= gnt_op_s ? op_cmd : dt_cmd;
                        wdata_r  <= gnt_op_s ? op_extend(op_wdata) : dt_wdata;
                        state_r  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rd_ok_r <= rd_ok_s;
                    state_r <= ST_RESP;
                    if (gnt_op_r) begin
                        op_sp_r  <= next_sp_s;
                        op_ack_r <= 1'b1;
                        if (cmd_r == SC_CLR) op_err_r <= 1'b0;
                        else if (bad_s)      op_err_r <= 1'b1;
                    end else begin
                        dt_sp_r  <= next_sp_s;
                        dt_ack_r <= 1'b1;
                        if (cmd_r == SC_CLR) dt_err_r <= 1'b0;
                        else if (bad_s)      dt_err_r <= 1'b1;
                    end
                end
                ST_RESP: begin
                    dt_ack_r <= 1'b0;
                    op_ack_r <= 1'b0;
                    state_r  <= ST_IDLE;
                    if (rd_ok_r) begin
                        if (gnt_op_r) op_rdata_r <= ram_q_s[CO_N-1:0];
                        else          dt_rdata_r <= ram_q_s;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // The RAM's registered output is presented during the ack cycle, then held locally.
    assign dt_rdata = (state_r == ST_RESP && rd_ok_r && !gnt_op_r) ? ram_q_s : dt_rdata_r;
    assign op_rdata = (state_r == ST_RESP && rd_ok_r && gnt_op_r) ? ram_q_s[CO_N-1:0] : op_rdata_r;
    assign dt_ack   = dt_ack_r;
    assign op_ack   = op_ack_r;
    assign dt_err   = dt_err_r;
    assign op_err   = op_err_r;
    assign dt_empty = (dt_sp_r == SP_ZERO);
    assign dt_full  = (dt_sp_r == SP_FULL);
    assign op_empty = (op_sp_r == SP_ZERO);
    assign op_full  = (op_sp_r == SP_FULL);

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed self-checking bench for stack_arbiter (expectations follow STACK_ARB_RR_EN).
module tb_stack_arbiter;
    import stack_arbiter_pkg::*;

    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [SC_N-1:0] dt_cmd, op_cmd;
    logic [CD_N-1:0] dt_wdata, dt_rdata;
    logic [CO_N-1:0] op_wdata, op_rdata;
    logic            dt_ack, dt_empty, dt_full, dt_err;
    logic            op_ack, op_empty, op_full, op_err;

    int checks = 0;
    int errors = 0;
    int lat, tdt, top;

    stack_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .dt_cmd(dt_cmd), .dt_wdata(dt_wdata), .dt_rdata(dt_rdata), .dt_ack(dt_ack),
        .dt_empty(dt_empty), .dt_full(dt_full), .dt_err(dt_err),
        .op_cmd(op_cmd), .op_wdata(op_wdata), .op_rdata(op_rdata), .op_ack(op_ack),
        .op_empty(op_empty), .op_full(op_full), .op_err(op_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one data-stack command; lat = negedges until ack (-1 on timeout).
    task automatic do_dt(input logic [SC_N-1:0] c, input logic [CD_N-1:0] w, output int l);
        dt_cmd = c; dt_wdata = w; l = -1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (dt_ack) begin l = n; break; end
        end
        dt_cmd = SC_NON;
        @(negedge clk);
    endtask

    task automatic do_op(input logic [SC_N-1:0] c, input logic [CO_N-1:0] w, output int l);
        op_cmd = c; op_wdata = w; l = -1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (op_ack) begin l = n; break; end
        end
        op_cmd = SC_NON;
        @(negedge clk);
    endtask

    // Both ports push in the same cycle; report each port's ack delay.
    task automatic do_both(input logic [CD_N-1:0] dw, input logic [CO_N-1:0] ow,
                           output int td, output int to);
        dt_cmd = SC_PUS; dt_wdata = dw; op_cmd = SC_PUS; op_wdata = ow;
        td = -1; to = -1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (dt_ack && td < 0) begin td = n; dt_cmd = SC_NON; end
            if (op_ack && to < 0) begin to = n; op_cmd = SC_NON; end
            if (td >= 0 && to >= 0) break;
        end
        dt_cmd = SC_NON; op_cmd = SC_NON;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; dt_cmd = SC_NON; op_cmd = SC_NON; dt_wdata = 8'h00; op_wdata = 4'h0;
        @(negedge clk); @(negedge clk);
        chk("rst_dt_empty", dt_empty, 1);  chk("rst_dt_full", dt_full, 0);
        chk("rst_op_empty", op_empty, 1);  chk("rst_acks", {dt_ack, op_ack}, 0);
        chk("rst_errs", {dt_err, op_err}, 0);
        chk("rst_dt_rdata", dt_rdata, 0);  chk("rst_op_rdata", op_rdata, 0);
        reset = 1'b0;
        @(negedge clk);

        // Data-stack push/push/pop
        do_dt(SC_PUS, 8'h12, lat); chk("dt_pus1_lat", lat, 2);
        do_dt(SC_PUS, 8'h34, lat); chk("dt_pus2_lat", lat, 2);
        do_dt(SC_POP, 8'h00, lat); chk("dt_pop_lat", lat, 2);
        chk("dt_pop_data", dt_rdata, 8'h34);
        chk("dt_not_empty", dt_empty, 0);
        @(negedge clk); @(negedge clk);
        chk("dt_rdata_held", dt_rdata, 8'h34);

        // Operator stack with underflow
        do_op(SC_PUS, 4'h3, lat); chk("op_pus_lat", lat, 2);
        do_op(SC_TOP, 4'h0, lat); chk("op_top_data", op_rdata, 4'h3);
        do_op(SC_POP, 4'h0, lat); chk("op_pop_data", op_rdata, 4'h3);
        chk("op_empty_after_pop", op_empty, 1);
        do_op(SC_POP, 4'h0, lat); chk("op_underflow_ack", lat, 2);
        chk("op_underflow_err", op_err, 1);
        chk("op_underflow_rdata", op_rdata, 4'h3);
        chk("dt_err_isolated", dt_err, 0);
        do_op(SC_CLR, 4'h0, lat); chk("op_clr_err", op_err, 0);
        do_op(SC_PUS, 4'h5, lat);

        // Fill data stack (one entry already present), then overflow
        for (int i = 1; i < DEPTH; i++) begin
            do_dt(SC_PUS, 8'h40 + 8'(i), lat);
            chk("dt_fill_lat", lat, 2);
        end
        chk("dt_full", dt_full, 1);
        do_dt(SC_PUS, 8'hAA, lat); chk("dt_ovf_ack", lat, 2);
        chk("dt_ovf_err", dt_err, 1);  chk("dt_ovf_full", dt_full, 1);
        do_dt(SC_TOP, 8'h00, lat); chk("dt_ovf_top_intact", dt_rdata, 8'h4F);
        do_dt(SC_CLR, 8'h00, lat);
        chk("dt_clr_empty", dt_empty, 1); chk("dt_clr_err", dt_err, 0);
        chk("dt_clr_full", dt_full, 0);   chk("op_untouched_empty", op_empty, 0);
        do_op(SC_TOP, 4'h0, lat); chk("op_untouched_top", op_rdata, 4'h5);

        // Contention
        do_both(8'h21, 4'h6, tdt, top);
        chk("arb1_dt", tdt, 2); chk("arb1_op", top, 5);
        do_both(8'h22, 4'h7, tdt, top);
`ifdef STACK_ARB_RR_EN
        chk("arb2_op", top, 2); chk("arb2_dt", tdt, 5);
`else
        chk("arb2_dt", tdt, 2); chk("arb2_op", top, 5);
`endif
        do_dt(SC_POP, 8'h00, lat); chk("arb_dt_data", dt_rdata, 8'h22);
        do_op(SC_POP, 4'h0, lat);  chk("arb_op_data", op_rdata, 4'h7);

        // Reset during ACCESS of a data push
        dt_cmd = SC_PUS; dt_wdata = 8'hEE;
        @(negedge clk);
        reset = 1'b1; dt_cmd = SC_NON;
        @(negedge clk);
        chk("midrst_no_ack", dt_ack, 0); chk("midrst_empty", dt_empty, 1);
        chk("midrst_op_empty", op_empty, 1); chk("midrst_dt_rdata", dt_rdata, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_no_ack2", dt_ack, 0);
        do_dt(SC_PUS, 8'h77, lat); chk("postrst_pus_lat", lat, 2);
        do_dt(SC_POP, 8'h00, lat); chk("postrst_pop", dt_rdata, 8'h77);
        chk("postrst_empty", dt_empty, 1);
        do_both(8'h31, 4'h9, tdt, top);
        chk("postrst_arb_dt", tdt, 2); chk("postrst_arb_op", top, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
